// File: rtl/camo_pkg.sv
// Shared types for the camouflaged cell array: per-channel mode encoding and key-loader FSM states.
package camo_pkg;

   typedef enum logic [1:0] {
      PASS = 2'b00,
      INV  = 2'b01,
      ONE  = 2'b10,
      ZERO = 2'b11
   } camo_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      FULL = 2'b10,
      RUN  = 2'b11
   } camo_state_e;

endpackage

// File: rtl/camo_cell.sv
// One obfuscated channel: a 2-bit mode selects pass, invert, or a constant level.
module camo_cell
   import camo_pkg::*;
(
   input  logic [1:0] mode,
   input  logic       din,
   output logic       dout
);

   // NOTE: every combinational output gets a default before the case so no latch is inferred.
   always_comb begin
      dout = 1'b0;
      case (camo_mode_e'(mode))
         PASS:    dout = din;
         INV:     dout = ~din;
         ONE:     dout = 1'b1;
         ZERO:    dout = 1'b0;
         default: dout = 1'b0;
      endcase
   end

endmodule

// File: rtl/camo_cell_array.sv
// Key-programmable array of camo_cell channels with a serial key loader.
// Define CAMO_OUT_REG_EN to register dout (one cycle of latency); default is combinational.
module camo_cell_array
   import camo_pkg::*;
#(
   parameter  int NCH   = 8,
   localparam int KEY_W = 2 * NCH
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] din,
   input  logic           key_sdi,
   input  logic           key_shift_en,
   input  logic           key_commit,
   output logic [NCH-1:0] dout,
   output logic           key_sdo,
   output logic           key_valid,
   output logic           key_full,
   output logic           key_err
);

   localparam int               CNT_W   = $clog2(KEY_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(KEY_W);

   camo_state_e      state_q, state_d;
   logic [KEY_W-1:0] shreg_q, shreg_d;
   logic [KEY_W-1:0] key_q,   key_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             key_valid_q, key_valid_d;
   logic             key_err_q,   key_err_d;
   logic [CNT_W-1:0] cnt_base;
   logic [NCH-1:0]   cell_out;
   logic [NCH-1:0]   dout_d;

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      key_d       = key_q;
      cnt_d       = cnt_q;
      key_valid_d = key_valid_q;
      key_err_d   = key_err_q;
      cnt_base    = cnt_q;

      // Shift wins over a simultaneous commit, and that commit raises no error.
      if (key_shift_en) begin
         shreg_d  = {key_sdi, shreg_q[KEY_W-1:1]};
         cnt_base = (state_q == RUN) ? '0 : cnt_q;
         cnt_d    = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
         state_d  = (cnt_d == CNT_MAX) ? FULL : LOAD;
      end else if (key_commit) begin
         case (state_q)
            FULL: begin
               key_d       = shreg_q;
               key_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = RUN;
            end
            IDLE, LOAD: key_err_d = 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: the key shift register and active key are cleared on reset so no stale key material survives.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         key_q       <= '0;
         cnt_q       <= '0;
         key_valid_q <= 1'b0;
         key_err_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         key_q       <= key_d;
         cnt_q       <= cnt_d;
         key_valid_q <= key_valid_d;
         key_err_q   <= key_err_d;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_cell
      camo_cell u_cell (
         .mode (key_q[2*i+1:2*i]),
         .din  (din[i]),
         .dout (cell_out[i])
      );
   end

   assign dout_d = key_valid_q ? cell_out : '0;

`ifdef CAMO_OUT_REG_EN
   logic [NCH-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (rst) dout_q <= '0;
      else     dout_q <= dout_d;
   end

   assign dout = dout_q;
`else
   assign dout = dout_d;
`endif

   assign key_sdo   = shreg_q[0];
   assign key_valid = key_valid_q;
   assign key_full  = (state_q == FULL);
   assign key_err   = key_err_q;

endmodule

// File: tb/tb_camo_cell_array.sv
// Directed self-checking bench for camo_cell_array with NCH=4 (KEY_W=8).
module tb_camo_cell_array;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] din = 4'b0000;
   logic       key_sdi = 1'b0;
   logic       key_shift_en = 1'b0;
   logic       key_commit = 1'b0;
   logic [3:0] dout;
   logic       key_sdo;
   logic       key_valid;
   logic       key_full;
   logic       key_err;

   int errors = 0;
   int checks = 0;

   camo_cell_array #(.NCH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .key_sdi      (key_sdi),
      .key_shift_en (key_shift_en),
      .key_commit   (key_commit),
      .dout         (dout),
      .key_sdo      (key_sdo),
      .key_valid    (key_valid),
      .key_full     (key_full),
      .key_err      (key_err)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Lets dout reflect the current din/key, whichever output style is built.
   task automatic settle_dout();
`ifdef CAMO_OUT_REG_EN
      cyc();
`else
      #1;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic shift_bits(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         key_sdi      = bits[i];
         key_shift_en = 1'b1;
         cyc();
         key_shift_en = 1'b0;
      end
   endtask

   task automatic commit_key();
      key_commit = 1'b1;
      cyc();
      key_commit = 1'b0;
   endtask

   task automatic test_reset();
      din = 4'b1111;
      do_reset();
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
      checks++; if (key_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", key_full); end
      checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", key_err); end
      checks++; if (key_sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo got=%b exp=0", key_sdo); end
      checks++; if (dout !== 4'b0000) begin errors++; $display("FAIL reset_dout got=%b exp=0000", dout); end
   endtask

   // Sequence 0,0,1,0,0,1,1,1: ch0 pass, ch1 invert, ch2 one, ch3 zero.
   task automatic test_basic_map();
      do_reset();
      din = 4'b0011;
      shift_bits(16'h00E4, 8);
      settle_dout();
      checks++; if (key_full !== 1'b1) begin errors++; $display("FAIL map_full got=%b exp=1", key_full); end
      checks++; if (key_sdo !== 1'b0) begin errors++; $display("FAIL map_sdo got=%b exp=0", key_sdo); end
      checks++; if (dout !== 4'b0000) begin errors++; $display("FAIL map_dout_pre got=%b exp=0000", dout); end
      commit_key();
      settle_dout();
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL map_valid got=%b exp=1", key_valid); end
      checks++; if (key_full !== 1'b0) begin errors++; $display("FAIL map_full_post got=%b exp=0", key_full); end
      checks++; if (dout !== 4'b0101) begin errors++; $display("FAIL map_dout_0011 got=%b exp=0101", dout); end
      din = 4'b1100;
      settle_dout();
      checks++; if (dout !== 4'b0110) begin errors++; $display("FAIL map_dout_1100 got=%b exp=0110", dout); end
   endtask

   task automatic test_early_commit();
      do_reset();
      din = 4'b1111;
      shift_bits(16'h00E4, 5);
      commit_key();
      settle_dout();
      checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL early_err got=%b exp=1", key_err); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL early_valid got=%b exp=0", key_valid); end
      checks++; if (dout !== 4'b0000) begin errors++; $display("FAIL early_dout got=%b exp=0000", dout); end
      shift_bits(16'h0007, 3);
      commit_key();
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL early_recommit_valid got=%b exp=1", key_valid); end
      checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL early_err_sticky got=%b exp=1", key_err); end
      do_reset();
      checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL early_err_cleared got=%b exp=0", key_err); end
   endtask

   task automatic test_shift_commit_same();
      do_reset();
      din = 4'b0011;
      shift_bits(16'h00E4, 7);
      key_sdi      = 1'b1;
      key_shift_en = 1'b1;
      key_commit   = 1'b1;
      cyc();
      key_shift_en = 1'b0;
      key_commit   = 1'b0;
      checks++; if (key_full !== 1'b1) begin errors++; $display("FAIL same_full got=%b exp=1", key_full); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL same_valid got=%b exp=0", key_valid); end
      checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL same_err got=%b exp=0", key_err); end
      commit_key();
      settle_dout();
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL same_next_valid got=%b exp=1", key_valid); end
      checks++; if (dout !== 4'b0101) begin errors++; $display("FAIL same_next_dout got=%b exp=0101", dout); end
   endtask

   // Starts in RUN with the 0101 mapping from the previous test.
   task automatic test_reload();
      din = 4'b0011;
      shift_bits(16'h0000, 1);
      settle_dout();
      checks++; if (key_full !== 1'b0) begin errors++; $display("FAIL reload_full_1 got=%b exp=0", key_full); end
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL reload_valid got=%b exp=1", key_valid); end
      checks++; if (dout !== 4'b0101) begin errors++; $display("FAIL reload_dout_load got=%b exp=0101", dout); end
      shift_bits(16'h0000, 7);
      settle_dout();
      checks++; if (key_full !== 1'b1) begin errors++; $display("FAIL reload_full_8 got=%b exp=1", key_full); end
      checks++; if (dout !== 4'b0101) begin errors++; $display("FAIL reload_dout_full got=%b exp=0101", dout); end
      commit_key();
      settle_dout();
      checks++; if (dout !== 4'b0011) begin errors++; $display("FAIL reload_dout_pass got=%b exp=0011", dout); end
      din = 4'b1010;
      settle_dout();
      checks++; if (dout !== 4'b1010) begin errors++; $display("FAIL reload_dout_1010 got=%b exp=1010", dout); end
   endtask

   // Bits 1,0,1,1,0,0,1,0,1,1: the first two fall off, bit 0 holds the third bit shifted in.
   task automatic test_saturate();
      do_reset();
      din = 4'b0011;
      shift_bits(16'h034D, 10);
      checks++; if (int'(dut.cnt_q) !== 8) begin errors++; $display("FAIL sat_count got=%0d exp=8", dut.cnt_q); end
      checks++; if (key_full !== 1'b1) begin errors++; $display("FAIL sat_full got=%b exp=1", key_full); end
      checks++; if (key_sdo !== 1'b1) begin errors++; $display("FAIL sat_sdo got=%b exp=1", key_sdo); end
      commit_key();
      settle_dout();
      checks++; if (dout !== 4'b0110) begin errors++; $display("FAIL sat_dout got=%b exp=0110", dout); end
   endtask

   task automatic test_reset_in_run();
      din = 4'b1111;
      do_reset();
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rrun_valid got=%b exp=0", key_valid); end
      checks++; if (dout !== 4'b0000) begin errors++; $display("FAIL rrun_dout got=%b exp=0000", dout); end
      checks++; if (key_full !== 1'b0) begin errors++; $display("FAIL rrun_full got=%b exp=0", key_full); end
      shift_bits(16'h0000, 8);
      commit_key();
      din = 4'b0000;
      settle_dout();
      checks++; if (dout !== 4'b0000) begin errors++; $display("FAIL rrun_step_pre got=%b exp=0000", dout); end
      din = 4'b1111;
      #1;
`ifdef CAMO_OUT_REG_EN
      checks++; if (dout !== 4'b0000) begin errors++; $display("FAIL rrun_step_lat got=%b exp=0000", dout); end
      cyc();
`endif
      checks++; if (dout !== 4'b1111) begin errors++; $display("FAIL rrun_step_post got=%b exp=1111", dout); end
   endtask

   initial begin
      test_reset();
      test_basic_map();
      test_early_commit();
      test_shift_commit_same();
      test_reload();
      test_saturate();
      test_reset_in_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
